tzn32: RTL and testbench

- Trailing-zero counter used by the GCD datapath (binary/Stein GCD shift-amount computation).
- Counts the zero bits below the least-significant set bit of a WIDTH-bit operand.
- Primary result is combinational, same cycle.
- A registered copy plus an all-zero flag are also provided for pipelined consumers.

---
 rtl/tzn_pkg.sv | 8 +
 rtl/tzn_group8.sv | 12 +
 rtl/tzn32.sv | 52 +++++
 tb/tb_tzn32.sv | 97 +++++++++
 4 files changed

// File: rtl/tzn_pkg.sv
// tzn_pkg: shared constants, count-width helper and count type for the trailing-zero counter
package tzn_pkg;
  localparam int TZN_GROUP = 8;
  function automatic int tzn_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction
  typedef logic [tzn_cnt_w(32)-1:0] tzn_cnt_t;
endpackage

// File: rtl/tzn_group8.sv
// tzn_group8: local trailing-zero count and all-zero flag for one 8-bit group
module tzn_group8 (
  input  logic [7:0] a_i,
  output logic [2:0] cnt_o,
  output logic       zero_o
);
  always_comb begin
    zero_o = ~|a_i;
    cnt_o  = a_i[0] ? 3'd0 : a_i[1] ? 3'd1 : a_i[2] ? 3'd2 : a_i[3] ? 3'd3 :
             a_i[4] ? 3'd4 : a_i[5] ? 3'd5 : a_i[6] ? 3'd6 : 3'd7;
  end
endmodule

// File: rtl/tzn32.sv
// tzn32: hierarchical trailing-zero counter with combinational and registered results
module tzn32
  import tzn_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  input  logic [WIDTH-1:0]             a_i,
  output logic [tzn_cnt_w(WIDTH)-1:0]  numz_o,
  output logic                         zero_o,
  output logic [tzn_cnt_w(WIDTH)-1:0]  numz_q_o,
  output logic                         zero_q_o
);
  localparam int CW = tzn_cnt_w(WIDTH);
  localparam int G  = WIDTH / TZN_GROUP;
  localparam int GW = G > 1 ? $clog2(G) : 1;
  logic [G-1:0][2:0] gcnt;
  logic [G-1:0]      gz;
  logic [GW-1:0]     gidx;
  logic [CW-2:0]     low;
  logic [CW-1:0]     numz_d, numz_q;
  logic              zero_d, zero_q;
  for (genvar g = 0; g < G; g++) begin : g_grp
    tzn_group8 u_grp (
      .a_i   (a_i[g*TZN_GROUP +: TZN_GROUP]),
      .cnt_o (gcnt[g]),
      .zero_o(gz[g])
    );
  end
  // scan from the top so the lowest non-zero group wins
  always_comb begin
    gidx = '0;
    for (int i = G - 1; i >= 0; i--)
      if (!gz[i]) gidx = GW'(i);
    low    = (CW-1)'({gidx, gcnt[gidx]});
    zero_d = &gz;
    numz_d = zero_d ? CW'(WIDTH) : {1'b0, low};
  end
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      numz_q <= '0;
      zero_q <= 1'b0;
    end else begin
      numz_q <= numz_d;
      zero_q <= zero_d;
    end
  assign numz_o   = numz_d;
  assign zero_o   = zero_d;
  assign numz_q_o = numz_q;
  assign zero_q_o = zero_q;
endmodule

// File: tb/tb_tzn32.sv
// tb_tzn32: randomized and directed check of tzn32 against a lowest-set-bit reference model
module tb_tzn32;
  import tzn_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  tzn_cnt_t    numz, numz_q;
  logic        zero, zero_q;
  int          total = 0, bad = 0;
  logic [31:0] prev = '0;
  bit          have_prev = 1'b0;

  tzn32 #(.WIDTH(32)) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .a_i     (a),
    .numz_o  (numz),
    .zero_o  (zero),
    .numz_q_o(numz_q),
    .zero_q_o(zero_q)
  );

  always #5 clk = ~clk;

  function automatic int ref_tz(input logic [31:0] v);
    for (int k = 0; k < 32; k++)
      if (v[k]) return k;
    return 32;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] v, input int exp = -1);
    @(posedge clk);
    #1 a = v;
    @(negedge clk);
    chk("numz", int'(numz), exp >= 0 ? exp : ref_tz(v));
    chk("zero", int'(zero), int'(v == 0));
    if (have_prev) begin
      chk("numz_q", int'(numz_q), ref_tz(prev));
      chk("zero_q", int'(zero_q), int'(prev == 0));
    end
    prev = v;
    have_prev = 1'b1;
  endtask

  initial begin
    logic [31:0] spot_v [11] = '{0, 1, 6, 8, 512, 999, 32'h100, 32'h10000,
                                 32'h1000000, 32'hFFFFFF00, 32'hFFFFFFFF};
    int          spot_e [11] = '{32, 0, 1, 3, 9, 0, 8, 16, 24, 8, 0};
    logic [31:0] r;
    #12;
    chk("rst_numz_q", int'(numz_q), 0);
    chk("rst_zero_q", int'(zero_q), 0);
    chk("rst_comb_numz", int'(numz), 32);
    chk("rst_comb_zero", int'(zero), 1);
    rst_n = 1'b1;
    prev = a;
    have_prev = 1'b1;
    for (int i = 0; i < 1000; i++) cyc(32'(i));
    for (int i = 0; i < 11; i++) cyc(spot_v[i], spot_e[i]);
    for (int k = 0; k < 32; k++) cyc(32'h1 << k, k);
    cyc(32'd6, 1);
    cyc(32'd0, 32);
    cyc(32'd0, 32);
    cyc(32'h20, 5);
    cyc(32'h20, 5);
    chk("pre_rst_numz_q", int'(numz_q), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_numz_q", int'(numz_q), 0);
    chk("async_zero_q", int'(zero_q), 0);
    chk("async_numz", int'(numz), 5);
    a = 32'h100;
    #1;
    chk("async_track", int'(numz), 8);
    chk("async_hold_q", int'(numz_q), 0);
    rst_n = 1'b1;
    prev = a;
    cyc(32'h100, 8);
    for (int i = 0; i < 10000; i++) begin
      r = $urandom;
      for (int m = $urandom_range(0, 4); m > 0; m--) r &= $urandom;
      if ($urandom_range(0, 3) == 0) r = r << $urandom_range(0, 31);
      if ($urandom_range(0, 49) == 0) r = '0;
      cyc(r);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
